seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Parametrised multiplexed 7-segment scan controller for the clock/display designs. It replaces the fixed 9-slot scan with a generic N-digit scanner. It adds blanking between digits (anti-ghosting), 16-level brightness PWM, per-digit blink and frame-coherent capture of digit data. Time-keeping blocks feed it raw segment patterns; it drives the shared `seg_data` and `seg_com` pins.

## Interface
- `DIGITS`, 8: number of digit positions scanned (2..16).
- `SCAN_DIV`, 1000: clock cycles per digit slot (≥ BLANK_CYC+1).
- `BLANK_CYC`, 16: cycles at slot start with all commons inactive (≥1).
- `BLINK_FRAMES`, 256: frames per blink half-period (≥1).
- `COM_ACTIVE_LOW`, 1: 1 = selected common driven 0, others 1; 0 = inverted.
- `BLANK_SEG`, 8'h00: `seg_data` value while blanked or disabled.

- `clk`  in  1: system clock, all logic on rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `en`  in  1: scan enable.
- `digit_in`  in  8*DIGITS: segment patterns; digit i = `digit_in[8i+7:8i]`.
- `blink_mask`  in  DIGITS: bit i = 1 blinks digit i.
- `bright`  in  4: brightness 0 (off) .. 15 (full).
- `seg_data`  out  8: segment pattern of the active digit.
- `seg_com`  out  DIGITS: digit commons; digit i drives `seg_com[DIGITS-1-i]`.
- `frame_tick`  out  1: one-cycle pulse at the start of each frame.

## Operation
- State consists of:
  - slot counter `cnt`, 0..SCAN_DIV-1;
  - digit index `idx`, 0..DIGITS-1;
  - 4-bit PWM counter `pwm`, which increments every enabled cycle and wraps 15→0;
  - frame counter for blink;
  - blink phase bit;
  - shadow registers for `digit_in` and `blink_mask`.
- The slot advances as follows:
  - `cnt` increments each enabled cycle.
  - At SCAN_DIV-1, `cnt` goes to 0 and `idx` increments.
  - At `idx` = DIGITS-1, `idx` wraps to 0, which ends the frame.
- Frame start is the enabled cycle with `idx`=0 and `cnt`=0. On it:
  - the shadows load `digit_in` and `blink_mask`;
  - `frame_tick` is registered high;
  - the blink frame counter increments;
  - when the blink frame counter reaches BLINK_FRAMES it clears and the blink phase toggles.
- Input changes at any other time are invisible until the next frame start.
- Digit `idx` is driven (its common active, `seg_data` = shadow pattern) only when all of the following hold:
  - `cnt` ≥ BLANK_CYC;
  - `bright`=15, or `pwm` < `bright`;
  - not (blink phase = 1 and shadow mask bit `idx` = 1).
- Otherwise all commons are inactive and `seg_data` = BLANK_SEG.
- `bright`=0 keeps the display dark. `bright` is sampled live, not shadowed.
- `en`=0 behaviour:
  - `cnt`, `idx` and `pwm` are held at 0; blink state and shadows are held.
  - Outputs go blank/inactive.
  - `frame_tick` stays 0.
  - On `en` returning to 1 the scan restarts at digit 0 with a frame start.
- Reset values:
  - all counters, the blink phase and the shadows are 0;
  - `seg_com` is all inactive (all 1s when COM_ACTIVE_LOW);
  - `seg_data` = BLANK_SEG;
  - `frame_tick` = 0.
- Reset applies immediately on assertion, including mid-frame. After release, the first enabled edge is a frame start.

## Timing
- `seg_data`, `seg_com` and `frame_tick` are registered. Each reflects the counter state of the previous cycle, a fixed 1-cycle latency.
- The shadow load and the `frame_tick` register occur on the same edge. BLANK_CYC ≥ 1 guarantees that no stale pattern is driven in the first slot.
- Frame length is DIGITS*SCAN_DIV cycles, so `frame_tick` period is DIGITS*SCAN_DIV.
- Blink half-period is BLINK_FRAMES frames, and blink phase 0 (visible) follows reset.
- At most one common is ever active. Every slot transition passes through ≥ BLANK_CYC fully inactive cycles.
- `en` falling: outputs are inactive from the next cycle.

## Test plan
- **Reset.** Hold `rst`=0 mid-scan → `seg_com`=all 1s, `seg_data`=8'h00 and `frame_tick`=0 without waiting for a clock. Release → first `frame_tick` 1 cycle after the first enabled edge.
- **Basic scan.** DIGITS=4, SCAN_DIV=8, BLANK_CYC=2, `bright`=15, `digit_in`=32'h44332211. Per slot, 2 cycles `seg_com`=4'b1111, then 6 cycles each of:
  - 4'b0111 / 8'h11;
  - 4'b1011 / 8'h22;
  - 4'b1101 / 8'h33;
  - 4'b1110 / 8'h44.
  
  `frame_tick` every 32 cycles.
- **Frame coherence.** Same setup; change `digit_in` to 32'hAABBCCDD during digit 1 → remaining digits keep showing 8'h22/33/44. 8'hDD/CC/BB/AA appear only after the next `frame_tick`.
- **Brightness.** SCAN_DIV=32, BLANK_CYC=16. `bright`=8 → exactly 8 active cycles per slot (first half of on-phase). `bright`=0 → `seg_com` never active over 2 frames. `bright`=15 → 16 active cycles per slot.
- **Blink.** BLINK_FRAMES=2, `blink_mask`=4'b0010 → digit 1 dark in frames 2,3,6,7 and visible in frames 0,1,4,5. Other digits are always visible.
- **Enable.** Drop `en` during digit 2 → all commons inactive next cycle, no `frame_tick`. Raise `en` → `frame_tick` next cycle, scan resumes at digit 0 after BLANK_CYC cycles.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
//   Generic N-digit multiplexed 7-segment scan controller. Each digit owns a
//   slot of SCAN_DIV cycles; the first BLANK_CYC cycles of every slot keep all
//   commons inactive so the previous digit's charge cannot ghost into the next
//   one. A free-running 4-bit PWM sets brightness, a frame-based blink phase
//   hides masked digits, and digit data/blink mask are captured once per
//   frame so a whole frame always shows one coherent set of patterns.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous reset, active low
//   en          scan enable; low holds the scan at digit 0 and blanks outputs
//   digit_in    8*DIGITS segment patterns, digit i = digit_in[8i+7:8i]
//   blink_mask  bit i set makes digit i blink
//   bright      brightness 0 (off) .. 15 (full), sampled live
//   seg_data    registered segment pattern of the active digit
//   seg_com     registered commons, digit i on seg_com[DIGITS-1-i]
//   frame_tick  registered one-cycle pulse at each frame start
// ---------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int         DIGITS         = 8,
    parameter int         SCAN_DIV       = 1000,
    parameter int         BLANK_CYC      = 16,
    parameter int         BLINK_FRAMES   = 256,
    parameter bit         COM_ACTIVE_LOW = 1'b1,
    parameter logic [7:0] BLANK_SEG      = 8'h00
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [8*DIGITS-1:0] digit_in,
    input  logic [DIGITS-1:0]   blink_mask,
    input  logic [3:0]          bright,
    output logic [7:0]          seg_data,
    output logic [DIGITS-1:0]   seg_com,
    output logic                frame_tick
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(DIGITS);
    localparam int BLK_W = $clog2(BLINK_FRAMES + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_BLANK = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [BLK_W-1:0]  BLK_FULL  = BLK_W'(BLINK_FRAMES);
    localparam logic [DIGITS-1:0] COM_OFF   = {DIGITS{COM_ACTIVE_LOW}};

    // One-hot common for digit `sel` (digit 0 on the MSB), polarity applied.
    function automatic logic [DIGITS-1:0] com_pattern(input logic [IDX_W-1:0] sel,
                                                      input logic             on);
        logic [DIGITS-1:0] onehot;
        onehot = on ? ({1'b1, {(DIGITS-1){1'b0}}} >> sel) : '0;
        return COM_ACTIVE_LOW ? ~onehot : onehot;
    endfunction

    logic [CNT_W-1:0]  cnt_p0;
    logic [IDX_W-1:0]  idx_p0;
    logic [3:0]        pwm_p0;
    logic [BLK_W-1:0]  blk_cnt_p0;
    logic              blink_ph_p0;
    logic [7:0]        sh_dig_p0 [DIGITS];
    logic [DIGITS-1:0] sh_mask_p0;

    logic              frame_start_p0;
    logic              drive_p0;

    logic [7:0]        seg_p1;
    logic [DIGITS-1:0] com_p1;
    logic              tick_p1;

    // ---- stage p0: scan position, PWM, blink and frame shadows ----
    assign frame_start_p0 = en && (idx_p0 == '0) && (cnt_p0 == '0);

    // The blanking window hides the shadow reload at frame start, so the
    // pattern selected here is always the one captured for this frame.
    assign drive_p0 = en
                   && (cnt_p0 >= CNT_BLANK)
                   && ((bright == 4'hF) || (pwm_p0 < bright))
                   && !(blink_ph_p0 && sh_mask_p0[idx_p0]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_p0 <= '0;
            idx_p0 <= '0;
            pwm_p0 <= '0;
        end else if (!en) begin
            cnt_p0 <= '0;
            idx_p0 <= '0;
            pwm_p0 <= '0;
        end else begin
            pwm_p0 <= pwm_p0 + 4'd1;
            if (cnt_p0 == CNT_LAST) begin
                cnt_p0 <= '0;
                idx_p0 <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + IDX_W'(1);
            end else begin
                cnt_p0 <= cnt_p0 + CNT_W'(1);
            end
        end
    end

    // blk_cnt_p0 counts frames begun in the current blink half-period. A frame
    // start that finds it already full opens the next half: the phase flips
    // and that frame becomes the first one counted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blk_cnt_p0  <= '0;
            blink_ph_p0 <= 1'b0;
            sh_mask_p0  <= '0;
            for (int i = 0; i < DIGITS; i++) sh_dig_p0[i] <= '0;
        end else if (frame_start_p0) begin
            sh_mask_p0 <= blink_mask;
            for (int i = 0; i < DIGITS; i++) sh_dig_p0[i] <= digit_in[8*i +: 8];
            if (blk_cnt_p0 == BLK_FULL) begin
                blk_cnt_p0  <= BLK_W'(1);
                blink_ph_p0 <= ~blink_ph_p0;
            end else begin
                blk_cnt_p0 <= blk_cnt_p0 + BLK_W'(1);
            end
        end
    end

    // ---- stage p1: registered pin drivers ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_p1  <= BLANK_SEG;
            com_p1  <= COM_OFF;
            tick_p1 <= 1'b0;
        end else begin
            seg_p1  <= drive_p0 ? sh_dig_p0[idx_p0] : BLANK_SEG;
            com_p1  <= com_pattern(idx_p0, drive_p0);
            tick_p1 <= frame_start_p0;
        end
    end

    assign seg_data   = seg_p1;
    assign seg_com    = com_p1;
    assign frame_tick = tick_p1;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_ctrl
//   Two instances share all inputs: dut_a (4 digits, 8-cycle slots, 2 blank
//   cycles, blink every 2 frames) and dut_b (4 digits, 32-cycle slots, 16
//   blank cycles). A reference model derives every expected output from the
//   number of enabled cycles since the scan (re)started and the number of
//   frames begun since reset, and is compared against both instances on every
//   falling edge. Directed sequences cover the multi-cycle corner cases.
// ---------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [31:0] digit_in   = '0;
    logic [3:0]  blink_mask = '0;
    logic [3:0]  bright     = 4'hF;

    logic [7:0]  seg_a, seg_b;
    logic [3:0]  com_a, com_b;
    logic        tick_a, tick_b;

    int n_chk  = 0;
    int n_fail = 0;
    bit mon_on = 1'b0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2), .BLINK_FRAMES(2),
        .COM_ACTIVE_LOW(1'b1), .BLANK_SEG(8'h00)
    ) dut_a (
        .clk(clk), .rst(rst), .en(en), .digit_in(digit_in),
        .blink_mask(blink_mask), .bright(bright),
        .seg_data(seg_a), .seg_com(com_a), .frame_tick(tick_a)
    );

    seg_scan_ctrl #(
        .DIGITS(4), .SCAN_DIV(32), .BLANK_CYC(16), .BLINK_FRAMES(2),
        .COM_ACTIVE_LOW(1'b1), .BLANK_SEG(8'h00)
    ) dut_b (
        .clk(clk), .rst(rst), .en(en), .digit_in(digit_in),
        .blink_mask(blink_mask), .bright(bright),
        .seg_data(seg_b), .seg_com(com_b), .frame_tick(tick_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          e;        // enabled cycles since scan (re)start
        int          k;        // frames begun since reset
        logic [31:0] sh_dig;
        logic [3:0]  sh_mask;
        logic [7:0]  seg;
        logic [3:0]  com;
        logic        tick;
    } model_t;

    function automatic model_t model_reset();
        model_t m;
        m.e = 0; m.k = 0; m.sh_dig = '0; m.sh_mask = '0;
        m.seg = 8'h00; m.com = 4'hF; m.tick = 1'b0;
        return m;
    endfunction

    function automatic model_t model_step(input model_t m, input int sd, input int bc,
                                          input int bf, input logic en_i,
                                          input logic [3:0] br, input logic [31:0] din,
                                          input logic [3:0] msk);
        model_t n;
        int     c, slot, pos, pwm;
        bit     phase, drive;
        n = m;
        n.tick = 1'b0;
        n.seg  = 8'h00;
        n.com  = 4'hF;
        if (!en_i) begin
            n.e = 0;
            return n;
        end
        c     = m.e % (4 * sd);
        slot  = c / sd;
        pos   = c % sd;
        pwm   = m.e % 16;
        phase = (m.k == 0) ? 1'b0 : (((m.k - 1) / bf) % 2 == 1);
        drive = (pos >= bc) && (br == 4'd15 || pwm < int'(br)) && !(phase && m.sh_mask[slot]);
        if (drive) begin
            n.com = ~(4'b1000 >> slot);
            n.seg = m.sh_dig[slot*8 +: 8];
        end
        if (c == 0) begin
            n.tick    = 1'b1;
            n.k       = m.k + 1;
            n.sh_dig  = din;
            n.sh_mask = msk;
        end
        n.e = m.e + 1;
        return n;
    endfunction

    model_t ma, mb;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ma <= model_reset();
            mb <= model_reset();
        end else begin
            ma <= model_step(ma, 8, 2, 2, en, bright, digit_in, blink_mask);
            mb <= model_step(mb, 32, 16, 2, en, bright, digit_in, blink_mask);
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            check("a_seg",  {24'd0, seg_a}, {24'd0, ma.seg});
            check("a_com",  {28'd0, com_a}, {28'd0, ma.com});
            check("a_tick", {31'd0, tick_a}, {31'd0, ma.tick});
            check("b_seg",  {24'd0, seg_b}, {24'd0, mb.seg});
            check("b_com",  {28'd0, com_b}, {28'd0, mb.com});
            check("b_tick", {31'd0, tick_b}, {31'd0, mb.tick});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random stimulus ----------------
    typedef struct {
        int          n;        // edge number since reset release
        logic        en;
        logic [3:0]  br;
        logic [31:0] din;
        logic [3:0]  com;
        logic [7:0]  seg;
        logic        tick;
    } vec_t;

    vec_t vt[11];

    initial begin
        int cur, t, act, d0, d1;

        vt[0]  = '{1,  1'b1, 4'hF, 32'h44332211, 4'b1111, 8'h00, 1'b1};
        vt[1]  = '{2,  1'b1, 4'hF, 32'h44332211, 4'b1111, 8'h00, 1'b0};
        vt[2]  = '{3,  1'b1, 4'hF, 32'h44332211, 4'b0111, 8'h11, 1'b0};
        vt[3]  = '{8,  1'b1, 4'hF, 32'h44332211, 4'b0111, 8'h11, 1'b0};
        vt[4]  = '{9,  1'b1, 4'hF, 32'h44332211, 4'b1111, 8'h00, 1'b0};
        vt[5]  = '{11, 1'b1, 4'hF, 32'h44332211, 4'b1011, 8'h22, 1'b0};
        vt[6]  = '{19, 1'b1, 4'hF, 32'h44332211, 4'b1101, 8'h33, 1'b0};
        vt[7]  = '{27, 1'b1, 4'hF, 32'h44332211, 4'b1110, 8'h44, 1'b0};
        vt[8]  = '{32, 1'b1, 4'hF, 32'h44332211, 4'b1110, 8'h44, 1'b0};
        vt[9]  = '{33, 1'b1, 4'hF, 32'h44332211, 4'b1111, 8'h00, 1'b1};
        vt[10] = '{35, 1'b1, 4'hF, 32'h44332211, 4'b0111, 8'h11, 1'b0};

        // Reset with the inputs already set up for the basic scan.
        en = 1'b1; bright = 4'hF; digit_in = 32'h44332211; blink_mask = '0;
        #1 rst = 1'b0;
        mon_on = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_com_a",  {28'd0, com_a}, 32'hF);
        check("rst_seg_a",  {24'd0, seg_a}, 32'h0);
        check("rst_tick_a", {31'd0, tick_a}, 32'h0);
        check("rst_com_b",  {28'd0, com_b}, 32'hF);
        rst = 1'b1;

        // Basic scan, table driven.
        cur = 0;
        for (int i = 0; i < 11; i++) begin
            en = vt[i].en; bright = vt[i].br; digit_in = vt[i].din;
            while (cur < vt[i].n) begin
                @(negedge clk);
                cur++;
            end
            check($sformatf("scan_com_n%0d", vt[i].n), {28'd0, com_a}, {28'd0, vt[i].com});
            check($sformatf("scan_seg_n%0d", vt[i].n), {24'd0, seg_a}, {24'd0, vt[i].seg});
            check($sformatf("scan_tick_n%0d", vt[i].n), {31'd0, tick_a}, {31'd0, vt[i].tick});
        end

        // Frame coherence: new data during digit 1 stays invisible this frame.
        t = 0;
        while (com_a !== 4'b1011 && t < 100) begin @(negedge clk); t++; end
        check("coh_wait_d1", t < 100, 1);
        digit_in = 32'hAABBCCDD;
        act = 0; t = 0;
        @(negedge clk);
        while (tick_a !== 1'b1 && t < 100) begin
            if (seg_a inside {8'hAA, 8'hBB, 8'hCC, 8'hDD}) act++;
            @(negedge clk); t++;
        end
        check("coh_wait_tick", t < 100, 1);
        check("coh_early_new", act, 0);
        repeat (2) @(negedge clk);
        check("coh_new_com", {28'd0, com_a}, 32'h7);
        check("coh_new_seg", {24'd0, seg_a}, 32'hDD);

        // Asynchronous reset mid-scan, checked between clock edges.
        #2 rst = 1'b0;
        #1;
        check("arst_com", {28'd0, com_a}, 32'hF);
        check("arst_seg", {24'd0, seg_a}, 32'h0);
        check("arst_tick", {31'd0, tick_a}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("arst_first_tick", {31'd0, tick_a}, 32'h1);

        // Brightness on dut_b: count active cycles per frame.
        t = 0;
        while (tick_b !== 1'b1 && t < 300) begin @(negedge clk); t++; end
        check("br_wait_tick", t < 300, 1);
        bright = 4'd8; act = 0;
        for (int i = 0; i < 128; i++) begin
            if (com_b !== 4'hF) act++;
            @(negedge clk);
        end
        check("br8_active", act, 32);
        bright = 4'd0; act = 0;
        for (int i = 0; i < 256; i++) begin
            if (com_b !== 4'hF) act++;
            @(negedge clk);
        end
        check("br0_active", act, 0);
        bright = 4'd15; act = 0;
        for (int i = 0; i < 128; i++) begin
            if (com_b !== 4'hF) act++;
            @(negedge clk);
        end
        check("br15_active", act, 64);

        // Blink on dut_a: frames counted from reset.
        rst = 1'b0;
        blink_mask = 4'b0010; digit_in = 32'h44332211; bright = 4'hF;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int f = 0; f < 8; f++) begin
            d0 = 0; d1 = 0;
            for (int i = 0; i < 32; i++) begin
                if (com_a === 4'b0111) d0++;
                if (com_a === 4'b1011) d1++;
                @(negedge clk);
            end
            check($sformatf("blink_d0_f%0d", f), d0, 6);
            check($sformatf("blink_d1_f%0d", f), d1, ((f / 2) % 2 == 1) ? 0 : 6);
        end

        // Enable dropped during digit 2, then restored.
        blink_mask = '0;
        t = 0;
        while (com_a !== 4'b1101 && t < 100) begin @(negedge clk); t++; end
        check("en_wait_d2", t < 100, 1);
        en = 1'b0;
        @(negedge clk);
        check("en_off_com", {28'd0, com_a}, 32'hF);
        check("en_off_seg", {24'd0, seg_a}, 32'h0);
        act = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (tick_a !== 1'b0 || com_a !== 4'hF) act++;
        end
        check("en_off_hold", act, 0);
        en = 1'b1;
        @(negedge clk);
        check("en_on_tick", {31'd0, tick_a}, 32'h1);
        check("en_on_blank", {28'd0, com_a}, 32'hF);
        @(negedge clk);
        check("en_on_blank2", {28'd0, com_a}, 32'hF);
        @(negedge clk);
        check("en_on_d0_com", {28'd0, com_a}, 32'h7);
        check("en_on_d0_seg", {24'd0, seg_a}, 32'h11);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 15) == 0) digit_in = $urandom;
            if ($urandom_range(0, 31) == 0) blink_mask = 4'($urandom);
            if ($urandom_range(0, 63) == 0) bright = 4'($urandom);
            if (en && $urandom_range(0, 63) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
        end

        @(negedge clk);
        mon_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
